// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encodings, default
// timing parameters and requester-index helpers.
package uart_tx_sched_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  // Defaults are also used by the receive-side controllers.
  localparam int DEF_TIMEOUT_CYC = 20000;
  localparam int DEF_GAP_CYC     = 16;

  localparam int IDX_W   = 3;
  localparam int MAX_REQ = 8;

  typedef logic [IDX_W-1:0] idx_t;

  function automatic idx_t wrap_inc(input idx_t idx, input int n);
    wrap_inc = (int'(idx) == n - 1) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// Combinational round-robin picker: first asserted request scanning upward
// from rr_ptr, wrapping modulo N_REQ.
module rr_pick
  import uart_tx_sched_pkg::*;
#(
  parameter int N_REQ = 4
)(
  input  logic [N_REQ-1:0] req,
  input  idx_t             rr_ptr,
  output logic             valid,
  output idx_t             win_idx
);

  logic [MAX_REQ-1:0] req_pad;
  idx_t               idx;

  // Scan from the far end so the candidate nearest rr_ptr is written last.
  always_comb begin
    req_pad = MAX_REQ'(req);
    valid   = 1'b0;
    win_idx = '0;
    idx     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = IDX_W'((int'(rr_ptr) + k) % N_REQ);
      if (req_pad[idx]) begin
        valid   = 1'b1;
        win_idx = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx among N_REQ byte producers, with
// inter-frame gap and tx_done timeout recovery.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int GAP_CYC     = DEF_GAP_CYC
)(
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] data,
  output logic [N_REQ-1:0]   ack,
  output logic [7:0]         tx_d_in,
  output logic               tx_en,
  input  logic               tx_done,
  output logic               busy,
  output logic [2:0]         cur_id,
  output logic               timeout_err
);

  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  logic [1:0]       state;
  idx_t             rr_ptr;
  logic             done_q;
  logic             done_rise;
  logic [TMR_W-1:0] timer;
  logic [GAP_W-1:0] gap_cnt;
  logic             pick_valid;
  idx_t             pick_idx;
  logic [7:0]       lane [MAX_REQ];

  assign done_rise = tx_done & ~done_q;

  always_comb begin
    for (int i = 0; i < MAX_REQ; i++) lane[i] = 8'h00;
    for (int i = 0; i < N_REQ; i++) lane[i] = data[8*i +: 8];
  end

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .valid   (pick_valid),
    .win_idx (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      done_q      <= 1'b0;
      timer       <= '0;
      gap_cnt     <= '0;
      ack         <= '0;
      tx_d_in     <= 8'h00;
      tx_en       <= 1'b0;
      busy        <= 1'b0;
      cur_id      <= '0;
      timeout_err <= 1'b0;
    end else begin
      done_q      <= tx_done;
      ack         <= '0;
      tx_en       <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            tx_d_in <= lane[pick_idx];
            ack     <= N_REQ'(1) << pick_idx;
            tx_en   <= 1'b1;
            cur_id  <= pick_idx;
            rr_ptr  <= wrap_inc(pick_idx, N_REQ);
            timer   <= '0;
            busy    <= 1'b1;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          timer <= timer + 1'b1;
          // A done edge coinciding with expiry counts as a normal completion.
          if (done_rise || timer == TMR_LAST) begin
            timeout_err <= ~done_rise;
            gap_cnt     <= '0;
            if (GAP_CYC == 0) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_cnt == GAP_LAST) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: scoreboarded grants, table-driven
// arbitration cases, timeout, mid-frame reset and a zero-gap build.
module tb_uart_tx_sched;

  localparam int N_REQ       = 4;
  localparam int TIMEOUT_CYC = 200;
  localparam int GAP_CYC     = 4;
  localparam int DONE_LAT    = 20;
  localparam int WAIT_MAX    = 2000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  req, req_b;
  logic [31:0] data, data_b;
  logic        resp_done, man_done, tx_done_a, tx_done_b;
  logic [3:0]  ack_a, ack_b;
  logic [7:0]  tx_d_in_a, tx_d_in_b;
  logic        tx_en_a, tx_en_b, busy_a, busy_b, timeout_err_a, timeout_err_b;
  logic [2:0]  cur_id_a, cur_id_b;

  assign tx_done_a = resp_done | man_done;

  uart_tx_sched #(.N_REQ(N_REQ), .TIMEOUT_CYC(TIMEOUT_CYC), .GAP_CYC(GAP_CYC)) dut_a (
    .clk(clk), .rst(rst), .req(req), .data(data), .ack(ack_a), .tx_d_in(tx_d_in_a),
    .tx_en(tx_en_a), .tx_done(tx_done_a), .busy(busy_a), .cur_id(cur_id_a),
    .timeout_err(timeout_err_a)
  );

  uart_tx_sched #(.N_REQ(N_REQ), .TIMEOUT_CYC(TIMEOUT_CYC), .GAP_CYC(0)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .data(data_b), .ack(ack_b), .tx_d_in(tx_d_in_b),
    .tx_en(tx_en_b), .tx_done(tx_done_b), .busy(busy_b), .cur_id(cur_id_b),
    .timeout_err(timeout_err_b)
  );

  typedef struct {
    logic [2:0] id;
    logic [7:0] byte_v;
  } exp_t;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [2:0]  exp_id;
    logic [7:0]  exp_byte;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t tbl [6];

  int n_checks = 0;
  int n_fail   = 0;
  int push_cnt = 0;
  int en_cnt   = 0;
  int ack_cnt  = 0;
  int to_cnt   = 0;
  int base_cnt;
  int wc;
  int seen_at;
  bit auto_done = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event did not occur as required", name);
  endfunction

  function automatic void expect_grant(input logic [2:0] id, input logic [7:0] b);
    exp_t e;
    e.id     = id;
    e.byte_v = b;
    sb_q.push_back(e);
    push_cnt++;
  endfunction

  task automatic wait_en_a(input string name);
    int c = 0;
    do begin @(negedge clk); c++; end while (!tx_en_a && c < WAIT_MAX);
    if (!tx_en_a) fail_now(name);
  endtask

  task automatic wait_idle_a(input string name);
    int c = 0;
    do begin @(negedge clk); c++; end while (busy_a && c < WAIT_MAX);
    if (busy_a) fail_now(name);
  endtask

  task automatic wait_en_b(input string name);
    int c = 0;
    do begin @(negedge clk); c++; end while (!tx_en_b && c < WAIT_MAX);
    if (!tx_en_b) fail_now(name);
  endtask

  task automatic reset_dut(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  // Scoreboard: every launch must match the next expected grant.
  always @(negedge clk) begin
    if (!rst) begin
      if (|ack_a) ack_cnt++;
      if (timeout_err_a) to_cnt++;
      if (tx_en_a) begin
        en_cnt++;
        if (sb_q.size() == 0) begin
          fail_now("unexpected_tx_en");
        end else begin
          mon_e = sb_q.pop_front();
          check("grant_id", 32'(cur_id_a), 32'(mon_e.id));
          check("grant_byte", 32'(tx_d_in_a), 32'(mon_e.byte_v));
          check("ack_onehot", 32'(ack_a), 32'(1) << mon_e.id);
        end
      end
    end
  end

  initial begin
    resp_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_en_a && auto_done) begin
        repeat (DONE_LAT) @(negedge clk);
        resp_done = 1'b1;
        @(negedge clk);
        resp_done = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{4'b0110, 32'hDEADBEEF, 3'd1, 8'hBE};
    tbl[1] = '{4'b0011, 32'h00FF7F80, 3'd0, 8'h80};
    tbl[2] = '{4'b1001, 32'h12345678, 3'd3, 8'h12};
    tbl[3] = '{4'b1100, 32'hCAFEF00D, 3'd2, 8'hFE};
    tbl[4] = '{4'b0111, 32'hA1B2C3D4, 3'd0, 8'hD4};
    tbl[5] = '{4'b1111, 32'h55AA33CC, 3'd1, 8'h33};

    rst = 1'b1; req = '0; data = '0; req_b = '0; data_b = '0;
    man_done = 1'b0; tx_done_b = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_ack", 32'(ack_a), 32'h0);
    check("rst_tx_en", 32'(tx_en_a), 32'h0);
    check("rst_busy", 32'(busy_a), 32'h0);
    check("rst_cur_id", 32'(cur_id_a), 32'h0);
    check("rst_timeout", 32'(timeout_err_a), 32'h0);
    check("rst_tx_d_in", 32'(tx_d_in_a), 32'h0);
    check("rst_busy_b", 32'(busy_b), 32'h0);
    rst = 1'b0;

    // Single request: 1-clk latency, 1-clk pulses, busy tail of GAP_CYC.
    data = 32'h00A50000;
    expect_grant(3'd2, 8'hA5);
    req = 4'b0100;
    @(negedge clk);
    check("t1_ack", 32'(ack_a), 32'h4);
    check("t1_tx_en", 32'(tx_en_a), 32'h1);
    req = '0;
    @(negedge clk);
    check("t1_ack_1clk", 32'(ack_a), 32'h0);
    check("t1_tx_en_1clk", 32'(tx_en_a), 32'h0);
    check("t1_busy", 32'(busy_a), 32'h1);
    repeat (3) @(negedge clk);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    repeat (GAP_CYC - 1) @(negedge clk);
    check("t1_busy_in_gap", 32'(busy_a), 32'h1);
    @(negedge clk);
    check("t1_busy_drop", 32'(busy_a), 32'h0);

    // Continuous requests from everyone: strict rotation.
    reset_dut(3);
    data = 32'h44332211;
    auto_done = 1'b1;
    expect_grant(3'd0, 8'h11);
    expect_grant(3'd1, 8'h22);
    expect_grant(3'd2, 8'h33);
    expect_grant(3'd3, 8'h44);
    expect_grant(3'd0, 8'h11);
    base_cnt = en_cnt;
    wc = 0;
    req = 4'b1111;
    while (en_cnt - base_cnt < 5 && wc < 5000) begin @(negedge clk); wc++; end
    req = '0;
    if (en_cnt - base_cnt < 5) fail_now("t2_five_grants");
    wait_idle_a("t2_idle");

    // Missing tx_done: timeout pulse, then the pending request is served.
    auto_done = 1'b0;
    data = 32'h00C45A00;
    expect_grant(3'd1, 8'h5A);
    req = 4'b0010;
    wait_en_a("t3_grant");
    req = 4'b0100;
    expect_grant(3'd2, 8'hC4);
    seen_at = 0;
    wc = 0;
    while (seen_at == 0 && wc < TIMEOUT_CYC + 5) begin
      @(negedge clk);
      wc++;
      if (timeout_err_a) seen_at = wc;
    end
    check("t3_timeout_cycle", 32'(seen_at), 32'(TIMEOUT_CYC));
    @(negedge clk);
    check("t3_timeout_1clk", 32'(timeout_err_a), 32'h0);
    auto_done = 1'b1;
    wait_en_a("t3_next_grant");
    req = '0;
    wait_idle_a("t3_idle");

    // Reset while waiting for tx_done.
    auto_done = 1'b0;
    data = 32'h00007700;
    expect_grant(3'd1, 8'h77);
    req = 4'b0010;
    wait_en_a("t4_grant");
    req = '0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t4_ack", 32'(ack_a), 32'h0);
    check("t4_tx_en", 32'(tx_en_a), 32'h0);
    check("t4_busy", 32'(busy_a), 32'h0);
    check("t4_cur_id", 32'(cur_id_a), 32'h0);
    check("t4_timeout", 32'(timeout_err_a), 32'h0);
    check("t4_tx_d_in", 32'(tx_d_in_a), 32'h0);
    rst = 1'b0;
    data = 32'hE1000099;
    expect_grant(3'd0, 8'h99);
    auto_done = 1'b1;
    req = 4'b1001;
    wait_en_a("t4_after_rst");
    req = '0;
    wait_idle_a("t4_idle");

    // Short request while busy must be ignored.
    data = 32'hC3000000;
    expect_grant(3'd3, 8'hC3);
    req = 4'b1000;
    wait_en_a("t5_grant");
    req = '0;
    @(negedge clk);
    req = 4'b0010;
    @(negedge clk);
    req = '0;
    wait_idle_a("t5_idle");
    repeat (10) @(negedge clk);

    // Arbitration table, starting from a fresh pointer.
    reset_dut(3);
    for (int i = 0; i < 6; i++) begin
      data = tbl[i].data;
      expect_grant(tbl[i].exp_id, tbl[i].exp_byte);
      req = tbl[i].req;
      wait_en_a("tbl_grant");
      check("tbl_cur_id", 32'(cur_id_a), 32'(tbl[i].exp_id));
      req = '0;
      wait_idle_a("tbl_idle");
    end

    check("en_eq_ack", 32'(en_cnt), 32'(ack_cnt));
    check("en_total", 32'(en_cnt), 32'(push_cnt));
    check("sb_empty", 32'(sb_q.size()), 32'h0);
    check("timeout_count", 32'(to_cnt), 32'h1);

    // Zero-gap build: relaunch one clock after each done edge.
    data_b = 32'h0000005A;
    req_b = 4'b0001;
    wait_en_b("t6_first");
    check("t6_ack", 32'(ack_b), 32'h1);
    check("t6_byte", 32'(tx_d_in_b), 32'h5A);
    for (int f = 0; f < 3; f++) begin
      repeat (5) @(negedge clk);
      tx_done_b = 1'b1;
      @(negedge clk);
      tx_done_b = 1'b0;
      check("t6_no_early_tx_en", 32'(tx_en_b), 32'h0);
      @(negedge clk);
      check("t6_b2b_tx_en", 32'(tx_en_b), 32'h1);
      check("t6_cur_id", 32'(cur_id_b), 32'h0);
    end
    req_b = '0;
    check("t6_no_timeout", 32'(timeout_err_b), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
